// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time,
// hands it to decode and waits for the execute-stage commit.
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_resp_valid,
    input  logic [31:0] ifu_resp_data,
    input  logic        ifu_resp_err,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        fetch_err_o,
    input  logic        commit_valid_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic [63:0] inst_cnt_o
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DELIVER,
        EXEC
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] jump_tgt;
    logic        resp_take;
    logic        commit_take;

    assign jump_tgt    = jump_addr_i & ~32'd3;
    assign resp_take   = (state == WAIT) && ifu_resp_valid;
    assign commit_take = (state == EXEC) && commit_valid_i;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (state)
            FETCH: begin
                if (ifu_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                if (ifu_resp_valid) state_nx = DELIVER;
            end
            DELIVER: begin
                if (inst_ready_i) state_nx = EXEC;
            end
            EXEC: begin
                if (commit_valid_i) begin
                    state_nx = FETCH;
                    pc_nx    = jump_flag_i ? jump_tgt : pc + 32'd4;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst_o      <= NOP_INST;
            inst_addr_o <= RESET_PC;
            fetch_err_o <= 1'b0;
            inst_cnt_o  <= 64'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (resp_take) begin
                inst_o      <= ifu_resp_err ? NOP_INST : ifu_resp_data;
                inst_addr_o <= pc;
                fetch_err_o <= ifu_resp_err;
            end
            if (commit_take) inst_cnt_o <= inst_cnt_o + 64'd1;
        end
    end

    // Outputs are masked while rst is high so the reset cycle is quiet.
    assign ifu_req_valid = (state == FETCH) && !rst;
    assign ifu_req_addr  = pc;
    assign inst_valid_o  = (state == DELIVER) && !rst;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the fetch unit with a phase-level reference model
// and a per-cycle compare process.
module tb_ysyx_23060332_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int PH_R = 0;
    localparam int PH_F = 1;
    localparam int PH_W = 2;
    localparam int PH_D = 3;
    localparam int PH_E = 4;

    logic        clk = 0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        fetch_err_o;
    logic        commit_valid_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [63:0] inst_cnt_o;

    ysyx_23060332_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .ifu_resp_err   (ifu_resp_err),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .fetch_err_o    (fetch_err_o),
        .commit_valid_i (commit_valid_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .inst_cnt_o     (inst_cnt_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 0;
    int          ph = PH_R;
    logic [31:0] exp_pc = RPC;
    logic [63:0] exp_cnt = 0;
    logic [31:0] exp_inst = NOP;
    logic [31:0] exp_addr = RPC;
    logic        exp_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_valid", 64'(ifu_req_valid), 64'(ph == PH_F));
            check("inst_valid", 64'(inst_valid_o), 64'(ph == PH_D));
            check("inst_cnt", inst_cnt_o, exp_cnt);
            if (ph == PH_F) check("req_addr", 64'(ifu_req_addr), 64'(exp_pc));
            if (ph == PH_D) begin
                check("inst", 64'(inst_o), 64'(exp_inst));
                check("inst_addr", 64'(inst_addr_o), 64'(exp_addr));
                check("fetch_err", 64'(fetch_err_o), 64'(exp_err));
            end
            if (ph == PH_R) begin
                check("rst_inst", 64'(inst_o), 64'(NOP));
                check("rst_addr", 64'(inst_addr_o), 64'(RPC));
                check("rst_err", 64'(fetch_err_o), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_inst(input logic [31:0] data, input logic err,
                            input int req_wait, input int dec_wait,
                            input int exec_wait, input logic jf,
                            input logic [31:0] ja);
        ifu_req_ready = 0;
        for (int i = 0; i < req_wait; i++) begin
            ifu_resp_valid = 1;
            ifu_resp_data  = 32'hBAD0_0000;
            tick();
        end
        // A response coinciding with acceptance must be ignored.
        ifu_req_ready  = 1;
        ifu_resp_valid = (req_wait > 0);
        ifu_resp_data  = 32'hBAD0_0001;
        tick();
        ph = PH_W;
        ifu_req_ready  = 0;
        ifu_resp_valid = 1;
        ifu_resp_data  = data;
        ifu_resp_err   = err;
        tick();
        ph       = PH_D;
        exp_inst = err ? NOP : data;
        exp_addr = exp_pc;
        exp_err  = err;
        ifu_resp_valid = 0;
        ifu_resp_err   = 0;
        inst_ready_i   = 0;
        commit_valid_i = (dec_wait > 0);
        for (int i = 0; i < dec_wait; i++) tick();
        inst_ready_i   = 1;
        commit_valid_i = 0;
        tick();
        ph = PH_E;
        inst_ready_i = 0;
        for (int i = 0; i < exec_wait; i++) begin
            ifu_resp_valid = 1;
            tick();
        end
        ifu_resp_valid = 0;
        commit_valid_i = 1;
        jump_flag_i    = jf;
        jump_addr_i    = ja;
        tick();
        commit_valid_i = 0;
        jump_flag_i    = 0;
        exp_pc  = jf ? {ja[31:2], 2'b00} : exp_pc + 32'd4;
        exp_cnt = exp_cnt + 64'd1;
        ph = PH_F;
    endtask

    initial begin
        rst = 1;
        ifu_req_ready  = 0;
        ifu_resp_valid = 0;
        ifu_resp_data  = 0;
        ifu_resp_err   = 0;
        inst_ready_i   = 0;
        commit_valid_i = 0;
        jump_flag_i    = 0;
        jump_addr_i    = 0;
        tick();
        ph = PH_R;
        chk_en = 1;
        tick();
        rst = 0;
        ph = PH_F;
        exp_pc = RPC;
        exp_cnt = 0;

        run_inst(32'h0010_0093, 0, 0, 0, 0, 0, 0);
        check("lit_inst1", 64'(inst_o), 64'h0010_0093);
        check("lit_iaddr1", 64'(inst_addr_o), 64'h8000_0000);
        check("lit_pc1", 64'(ifu_req_addr), 64'h8000_0004);
        check("lit_cnt1", inst_cnt_o, 64'd1);

        run_inst(32'h0020_0113, 0, 0, 0, 1, 0, 0);
        run_inst(32'h0000_006F, 0, 0, 0, 0, 1, 32'h8000_0101);
        check("lit_jump", 64'(ifu_req_addr), 64'h8000_0100);

        run_inst(32'h1234_5678, 0, 3, 4, 2, 0, 0);
        run_inst(32'hDEAD_BEEF, 1, 0, 1, 1, 0, 0);
        check("lit_nop", 64'(inst_o), 64'h0000_0013);
        check("lit_err", 64'(fetch_err_o), 64'd1);
        check("lit_pc_err", 64'(ifu_req_addr), 64'h8000_0108);

        ifu_req_ready = 1;
        tick();
        ph = PH_W;
        ifu_req_ready = 0;
        rst = 1;
        tick();
        ph = PH_R;
        exp_cnt = 0;
        tick();
        rst = 0;
        ph = PH_F;
        exp_pc = RPC;
        check("lit_rst_pc", 64'(ifu_req_addr), 64'h8000_0000);
        check("lit_rst_cnt", inst_cnt_o, 64'd0);

        run_inst(32'h0000_0067, 0, 1, 0, 0, 1, 32'hFFFF_FFFE);
        check("lit_top", 64'(ifu_req_addr), 64'hFFFF_FFFC);
        run_inst(32'h0000_0013, 0, 0, 0, 0, 0, 0);
        check("lit_wrap", 64'(ifu_req_addr), 64'h0000_0000);
        check("lit_cnt2", inst_cnt_o, 64'd2);

        tick();
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
